// File: rtl/operand_buffer.sv
// Double-buffered DIM x DIM weight/matrix tile store between host loader and systolic array.
// Latency: a commit with the active bank free swaps at that edge; new tile visible next cycle.
// Backpressure: load_ready drops while a commit waits for the array's ack; writes then are dropped.
module operand_buffer #(
    parameter  int DATA_W  = 8,
    parameter  int DIM     = 2,
    localparam int TILE    = DIM * DIM,
    localparam int ENTRIES = 2 * TILE,
    localparam int ADDR_W  = ($clog2(ENTRIES) > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_en,
    input  logic                     auto_inc,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     commit,
    input  logic                     err_clr,
    output logic                     load_ready,
    output logic                     full,
    output logic                     load_err,
    output logic                     out_valid,
    input  logic                     out_ack,
    output logic [TILE*DATA_W-1:0]   weights_o,
    output logic [TILE*DATA_W-1:0]   mats_o
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HELD = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_bank_sel;
    logic [DATA_W-1:0]      r_bank0 [ENTRIES];
    logic [DATA_W-1:0]      r_bank1 [ENTRIES];
    logic [ENTRIES-1:0]     r_mask;
    logic [ADDR_W-1:0]      r_ptr;
    logic                   r_out_valid;
    logic                   r_load_err;

    logic [ADDR_W-1:0]      w_wr_addr;
    logic                   w_addr_ok;
    logic                   w_wr_en;
    logic                   w_drop;
    logic                   w_free;
    logic                   w_swap;
    logic [TILE*DATA_W-1:0] w_weights;
    logic [TILE*DATA_W-1:0] w_mats;

    // The pointer never leaves 0..ENTRIES-1, so only explicit addresses need a range check.
    assign w_wr_addr = auto_inc ? r_ptr : load_addr;
    assign w_addr_ok = auto_inc || (int'(load_addr) < ENTRIES);
    assign w_wr_en   = load_en && (r_state == S_FILL) && w_addr_ok;
    assign w_drop    = load_en && ((r_state == S_HELD) || !w_addr_ok);
    // The active bank can be replaced when it is empty or being consumed this cycle.
    assign w_free    = !r_out_valid || out_ack;

    // Shadow state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and swap decision; commits arriving while HELD are ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        case (r_state)
            S_FILL: begin
                if (commit) begin
                    if (w_free) begin
                        w_swap = 1'b1;
                    end else begin
                        w_state_nxt = S_HELD;
                    end
                end
            end
            S_HELD: begin
                if (w_free) begin
                    w_swap      = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Element storage: writes land in the shadow bank before any same-edge swap takes effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_bank0[i] <= '0;
                r_bank1[i] <= '0;
            end
        end else if (w_wr_en) begin
            if (r_bank_sel) begin
                r_bank0[w_wr_addr] <= load_data;
            end else begin
                r_bank1[w_wr_addr] <= load_data;
            end
        end
    end

    // Bank select, fill tracking and pointer; a swap restarts the fill of the new shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_sel <= 1'b0;
            r_mask     <= '0;
            r_ptr      <= '0;
        end else if (w_swap) begin
            r_bank_sel <= ~r_bank_sel;
            r_mask     <= '0;
            r_ptr      <= '0;
        end else if (w_wr_en) begin
            r_mask[w_wr_addr] <= 1'b1;
            if (auto_inc) begin
                if (r_ptr == ADDR_W'(ENTRIES - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
        end
    end

    // Output handshake: a swap presents a fresh tile, a bare ack retires the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (w_swap) begin
            r_out_valid <= 1'b1;
        end else if (out_ack) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_err <= 1'b0;
        end else if (w_drop) begin
            r_load_err <= 1'b1;
        end else if (err_clr) begin
            r_load_err <= 1'b0;
        end
    end

    // Flatten the active bank onto the array-facing buses.
    always_comb begin
        w_weights = '0;
        w_mats    = '0;
        for (int k = 0; k < TILE; k++) begin
            w_weights[k*DATA_W +: DATA_W] = r_bank_sel ? r_bank1[k]      : r_bank0[k];
            w_mats[k*DATA_W +: DATA_W]    = r_bank_sel ? r_bank1[TILE+k] : r_bank0[TILE+k];
        end
    end

    assign weights_o  = w_weights;
    assign mats_o     = w_mats;
    assign load_ready = (r_state == S_FILL);
    assign full       = &r_mask;
    assign load_err   = r_load_err;
    assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_operand_buffer.sv
// Bench for operand_buffer: directed scenarios then random traffic against a tile-level model.
// Latency: inputs driven 1ns after posedge, outputs compared 1ns after the following posedge.
// Backpressure: the model tracks the pending-commit condition and expected load_ready.
module tb_operand_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0, auto_inc = 1'b0, commit = 1'b0, err_clr = 1'b0, out_ack = 1'b0;
    logic [2:0]  load_addr = '0;
    logic [7:0]  load_data = '0;
    logic        load_ready, full, load_err, out_valid;
    logic [31:0] weights_o, mats_o;

    logic        d3_load_en = 1'b0, d3_auto_inc = 1'b0, d3_commit = 1'b0, d3_err_clr = 1'b0, d3_out_ack = 1'b0;
    logic [4:0]  d3_load_addr = '0;
    logic [7:0]  d3_load_data = '0;
    logic        d3_load_ready, d3_full, d3_load_err, d3_out_valid;
    logic [71:0] d3_weights_o, d3_mats_o;

    int n_cmp = 0;
    int n_mis = 0;

    // Tile-level model: the tile the array sees and the tile being assembled.
    logic [7:0] m_act [8];
    logic [7:0] m_shd [8];
    bit         m_wr  [8];
    int         m_ptr;
    bit         m_held, m_valid, m_err;

    operand_buffer #(.DATA_W(8), .DIM(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .auto_inc(auto_inc),
        .load_addr(load_addr), .load_data(load_data), .commit(commit), .err_clr(err_clr),
        .load_ready(load_ready), .full(full), .load_err(load_err), .out_valid(out_valid),
        .out_ack(out_ack), .weights_o(weights_o), .mats_o(mats_o)
    );

    operand_buffer #(.DATA_W(8), .DIM(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .load_en(d3_load_en), .auto_inc(d3_auto_inc),
        .load_addr(d3_load_addr), .load_data(d3_load_data), .commit(d3_commit), .err_clr(d3_err_clr),
        .load_ready(d3_load_ready), .full(d3_full), .load_err(d3_load_err), .out_valid(d3_out_valid),
        .out_ack(d3_out_ack), .weights_o(d3_weights_o), .mats_o(d3_mats_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000ns");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_act[i] = 8'h00;
            m_shd[i] = 8'h00;
            m_wr[i]  = 1'b0;
        end
        m_ptr   = 0;
        m_held  = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock edge of the model, using the inputs that were stable across that edge.
    task automatic model_update();
        int         addr;
        bit         addr_ok, free, drop, swap;
        logic [7:0] tmp;
        addr    = auto_inc ? m_ptr : int'(load_addr);
        addr_ok = auto_inc || (int'(load_addr) < 8);
        free    = !m_valid || out_ack;
        drop    = load_en && (m_held || !addr_ok);
        if (load_en && !m_held && addr_ok) begin
            m_shd[addr] = load_data;
            m_wr[addr]  = 1'b1;
            if (auto_inc) m_ptr = (m_ptr + 1) % 8;
        end
        swap = free && (m_held || commit);
        if (swap) begin
            for (int i = 0; i < 8; i++) begin
                tmp      = m_act[i];
                m_act[i] = m_shd[i];
                m_shd[i] = tmp;
                m_wr[i]  = 1'b0;
            end
            m_ptr   = 0;
            m_held  = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (commit && !m_held) m_held = 1'b1;
            if (out_ack) m_valid = 1'b0;
        end
        if (drop) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ew, em;
        bit          ef;
        ef = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ew[k*8 +: 8] = m_act[k];
            em[k*8 +: 8] = m_act[4+k];
        end
        for (int k = 0; k < 8; k++) if (!m_wr[k]) ef = 1'b0;
        chk({tag, ".weights"}, weights_o, ew);
        chk({tag, ".mats"}, mats_o, em);
        chk({tag, ".valid"}, out_valid, m_valid);
        chk({tag, ".ready"}, load_ready, !m_held);
        chk({tag, ".full"}, full, ef);
        chk({tag, ".err"}, load_err, m_err);
    endtask

    task automatic idle();
        load_en = 1'b0; auto_inc = 1'b0; commit = 1'b0; err_clr = 1'b0; out_ack = 1'b0;
        load_addr = '0; load_data = '0;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();

        // Reset state, sampled while reset is held.
        #7;
        check_all("reset");
        chk("reset.d3_err", d3_load_err, 1'b0);
        chk("reset.d3_ready", d3_load_ready, 1'b1);
        #5 rst_n = 1'b1;

        // DIM=3: explicit address past the 18-entry store is dropped.
        d3_load_en = 1'b1; d3_auto_inc = 1'b0; d3_load_addr = 5'd20; d3_load_data = 8'h5A;
        step("d3_oob");
        chk("d3_oob.err", d3_load_err, 1'b1);
        chk("d3_oob.full", d3_full, 1'b0);
        d3_load_addr = 5'd17; d3_err_clr = 1'b1;
        step("d3_last");
        chk("d3_last.err", d3_load_err, 1'b0);
        d3_load_en = 1'b0; d3_err_clr = 1'b0;

        // Fill 01..08 with the pointer and commit into an empty output.
        for (int i = 1; i <= 8; i++) begin
            load_en = 1'b1; auto_inc = 1'b1; load_data = 8'(i);
            step("fill_a");
            if (i == 7) chk("fill_a.full7", full, 1'b0);
        end
        chk("fill_a.full8", full, 1'b1);
        idle(); commit = 1'b1;
        step("commit_a");
        chk("commit_a.w", weights_o, 32'h04030201);
        chk("commit_a.m", mats_o, 32'h08070605);
        chk("commit_a.v", out_valid, 1'b1);
        chk("commit_a.full", full, 1'b0);

        // Second tile while the first is unconsumed: commit must wait.
        for (int i = 1; i <= 8; i++) begin
            idle(); load_en = 1'b1; auto_inc = 1'b1; load_data = 8'h10 + 8'(i);
            step("fill_b");
        end
        idle(); commit = 1'b1;
        step("commit_b");
        chk("held.ready", load_ready, 1'b0);
        chk("held.w", weights_o, 32'h04030201);
        idle(); load_en = 1'b1; load_addr = 3'd0; load_data = 8'hFF;
        step("held_write");
        chk("held_write.err", load_err, 1'b1);
        idle(); err_clr = 1'b1;
        step("err_clr");
        chk("err_clr.err", load_err, 1'b0);
        idle(); err_clr = 1'b1; load_en = 1'b1; load_addr = 3'd2; load_data = 8'hCC;
        step("clr_vs_drop");
        idle(); err_clr = 1'b1;
        step("err_clr2");
        // Ack releases the held commit; the write in the same cycle is dropped.
        idle(); out_ack = 1'b1; load_en = 1'b1; load_addr = 3'd1; load_data = 8'hEE;
        step("ack_swap");
        chk("ack_swap.w", weights_o, 32'h14131211);
        chk("ack_swap.m", mats_o, 32'h18171615);
        chk("ack_swap.v", out_valid, 1'b1);

        // Consume the tile, then nine pointer writes wrap onto entry 0.
        idle(); err_clr = 1'b1; out_ack = 1'b1;
        step("ack_only");
        for (int i = 1; i <= 9; i++) begin
            idle(); load_en = 1'b1; auto_inc = 1'b1; load_data = 8'h20 + 8'(i);
            step("wrap");
            if (i == 8) chk("wrap.full8", full, 1'b1);
        end
        idle(); commit = 1'b1;
        step("commit_wrap");
        chk("commit_wrap.w", weights_o, 32'h24232229);
        chk("commit_wrap.m", mats_o, 32'h28272625);

        // Write, ack and commit together: the write is part of the committed tile.
        idle(); commit = 1'b1; out_ack = 1'b1; load_en = 1'b1; load_addr = 3'd7; load_data = 8'hAA;
        step("commit_wr");
        chk("commit_wr.m", mats_o, 32'hAA171615);
        chk("commit_wr.w", weights_o, 32'h14131211);

        // Reset in the middle of a held commit.
        idle(); commit = 1'b1;
        step("held_c");
        idle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.w", weights_o, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        commit = 1'b1;
        step("post_rst_commit");
        chk("post_rst.w", weights_o, 32'h0);
        chk("post_rst.v", out_valid, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            load_en   = ($urandom_range(0, 99) < 50);
            auto_inc  = ($urandom_range(0, 99) < 70);
            load_addr = 3'($urandom_range(0, 7));
            load_data = 8'($urandom);
            commit    = ($urandom_range(0, 99) < 15);
            out_ack   = ($urandom_range(0, 99) < 25);
            err_clr   = ($urandom_range(0, 99) < 10);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
